// File: rtl/taxi_axis_cobs_encode_seg_if.sv
// Byte-oriented AXI4-Stream bundle shared by the COBS encoder and its neighbours.
// The src view drives the payload; the snk view returns tready.
interface taxi_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_axis_cobs_encode_seg.sv
// COBS encoder with a two-bank segment buffer: one bank fills from s_axis while the
// other drains through a small output FSM and a 2-entry skid register onto m_axis.
module taxi_axis_cobs_encode_seg #(
  parameter int MAX_SEG      = 255,
  parameter bit APPEND_ZERO  = 1'b1,
  parameter bit PREPEND_ZERO = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  taxi_axis_if.snk s_axis,
  taxi_axis_if.src m_axis,
  output logic     status_frame,
  output logic     status_bad_frame,
  output logic     status_long_seg
);
  localparam int         DEPTH    = MAX_SEG - 1;
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] MAX_CNT  = 8'(DEPTH);
  localparam logic [7:0] MAX_CODE = 8'(MAX_SEG);

  typedef struct packed {
    logic [7:0] code;
    logic       extra_one;
    logic       last;
    logic       err;
    logic       first;
  } desc_t;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef enum logic [2:0] {S_IDLE, S_CODE, S_DATA, S_ONE, S_TERM} state_t;

  // ---------------- input side: fill bank wr_bank ----------------
  logic [7:0] mem [2][DEPTH];
  desc_t      desc [2];
  logic [1:0] bank_full;
  logic       wr_bank;
  logic       rd_bank;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       in_first;
  logic       in_ready;
  logic       s_fire;
  logic       s_zero;
  logic       close;
  logic       wr_en;
  logic       long_seg;
  desc_t      close_desc;
  logic       free;
  logic       unused_sink;

  assign s_axis.tready = in_ready && !bank_full[wr_bank];
  assign s_fire        = s_axis.tvalid && s_axis.tready;
  assign s_zero        = (s_axis.tdata == 8'h00);
  assign unused_sink   = ^{s_axis.tkeep, s_axis.tid, s_axis.tdest};

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    close            = 1'b0;
    wr_en            = 1'b0;
    long_seg         = 1'b0;
    cnt_n            = cnt;
    close_desc       = '0;
    close_desc.first = in_first;
    if (s_fire) begin
      if (s_axis.tlast && s_axis.tuser[0]) begin
        close           = 1'b1;
        close_desc.code = cnt + 8'd1;
        close_desc.last = 1'b1;
        close_desc.err  = 1'b1;
      end else if (s_zero) begin
        close                = 1'b1;
        close_desc.code      = cnt + 8'd1;
        close_desc.extra_one = s_axis.tlast;
        close_desc.last      = s_axis.tlast;
      end else begin
        wr_en = 1'b1;
        if (cnt + 8'd1 == MAX_CNT) begin
          // Full-length segment carries no implied zero, so a final one needs no trailing 0x01.
          close           = 1'b1;
          close_desc.code = MAX_CODE;
          close_desc.last = s_axis.tlast;
          long_seg        = 1'b1;
        end else if (s_axis.tlast) begin
          close           = 1'b1;
          close_desc.code = cnt + 8'd2;
          close_desc.last = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      if (close) cnt_n = '0;
    end
  end

  // NOTE: the segment RAM is not reset; bank_full guards every read, and leaving it out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][cnt[AW-1:0]] <= s_axis.tdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      wr_bank   <= 1'b0;
      cnt       <= '0;
      in_first  <= 1'b1;
      bank_full <= '0;
      desc      <= '{default: '0};
    end else begin
      in_ready <= 1'b1;
      cnt      <= cnt_n;
      if (free) bank_full[rd_bank] <= 1'b0;
      if (close) begin
        bank_full[wr_bank] <= 1'b1;
        desc[wr_bank]      <= close_desc;
        wr_bank            <= !wr_bank;
        in_first           <= close_desc.last;
      end
    end
  end

  // ---------------- output side: drain bank rd_bank ----------------
  state_t     state;
  state_t     state_n;
  logic [7:0] idx;
  logic [7:0] idx_n;
  desc_t      rd_desc;
  logic [7:0] rd_byte;
  logic       has_term;
  logic       emit_code;
  logic       push;
  beat_t      push_beat;
  beat_t      fifo [2];
  logic       wptr;
  logic       rptr;
  logic [1:0] fcnt;
  logic       space;
  logic       pop;

  assign rd_desc  = desc[rd_bank];
  assign rd_byte  = mem[rd_bank][idx[AW-1:0]];
  assign has_term = rd_desc.last && APPEND_ZERO;
  assign space    = (fcnt != 2'd2);

  function automatic state_t tail_next(input logic one_pending, input logic term_pending);
    if (one_pending) return S_ONE;
    if (term_pending) return S_TERM;
    return S_IDLE;
  endfunction

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    push      = 1'b0;
    push_beat = '0;
    emit_code = 1'b0;
    free      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bank_full[rd_bank] && space) begin
          if (PREPEND_ZERO && rd_desc.first) begin
            push    = 1'b1;
            state_n = S_CODE;
          end else begin
            emit_code = 1'b1;
          end
        end
      end
      S_CODE: emit_code = space;
      S_DATA: begin
        if (space) begin
          push           = 1'b1;
          push_beat.data = rd_byte;
          if (idx == rd_desc.code - 8'd2) state_n = tail_next(rd_desc.extra_one, has_term);
          else idx_n = idx + 8'd1;
        end
      end
      S_ONE: begin
        if (space) begin
          push           = 1'b1;
          push_beat.data = 8'h01;
          state_n        = tail_next(1'b0, has_term);
        end
      end
      S_TERM: begin
        if (space) begin
          push    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (emit_code) begin
      push           = 1'b1;
      push_beat.data = rd_desc.code;
      if (rd_desc.code != 8'd1) begin
        state_n = S_DATA;
        idx_n   = '0;
      end else begin
        state_n = tail_next(rd_desc.extra_one, has_term);
      end
    end
    // Returning to IDLE on a pushed byte means this byte ends the segment's sequence.
    if (push && state_n == S_IDLE) begin
      free           = 1'b1;
      push_beat.last = rd_desc.last;
      push_beat.user = rd_desc.last && rd_desc.err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      rd_bank <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (free) rd_bank <= !rd_bank;
    end
  end

  // ---------------- 2-entry skid register ----------------
  assign pop           = m_axis.tvalid && m_axis.tready;
  assign m_axis.tvalid = (fcnt != 2'd0);
  assign m_axis.tdata  = fifo[rptr].data;
  assign m_axis.tlast  = fifo[rptr].last;
  assign m_axis.tuser  = fifo[rptr].user;
  assign m_axis.tkeep  = '1;
  assign m_axis.tid    = '0;
  assign m_axis.tdest  = '0;

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= push_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr             <= 1'b0;
      rptr             <= 1'b0;
      fcnt             <= '0;
      status_frame     <= 1'b0;
      status_bad_frame <= 1'b0;
      status_long_seg  <= 1'b0;
    end else begin
      if (push) wptr <= !wptr;
      if (pop) rptr <= !rptr;
      fcnt             <= fcnt + 2'(push) - 2'(pop);
      status_frame     <= pop && fifo[rptr].last;
      status_bad_frame <= pop && fifo[rptr].last && fifo[rptr].user;
      status_long_seg  <= long_seg;
    end
  end
endmodule

// File: tb/tb_taxi_axis_cobs_encode_seg.sv
// Directed bench for the COBS encoder: three instances cover MAX_SEG=255, MAX_SEG=4 with
// terminator, and MAX_SEG=4 with leading delimiter and tlast on the final byte.
module tb_taxi_axis_cobs_encode_seg;
  localparam int LIMIT   = 3000;
  localparam int D2_MAX  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_data [3];
  logic       s_valid [3];
  logic       s_last [3];
  logic       s_user [3];
  logic       s_ready [3];
  logic       m_hold [3];
  logic       m_ready [3];
  logic       m_valid [3];
  logic       m_last [3];
  logic       m_user [3];
  logic [7:0] m_data [3];
  logic       st_frame [3];
  logic       st_bad [3];
  logic       st_long [3];
  logic       rand_en = 1'b0;
  logic       rnd_ready = 1'b1;

  int total = 0;
  int bad = 0;
  logic [9:0] out_q [3][$];
  int n_last [3];
  int n_frame [3];
  int n_bad [3];
  int n_long [3];
  int sent_b [$];
  int sent_len [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    taxi_axis_if #(.DATA_W(8), .USER_W(1)) s_if ();
    taxi_axis_if #(.DATA_W(8), .USER_W(1)) m_if ();

    assign s_if.tdata  = s_data[g];
    assign s_if.tkeep  = 1'b1;
    assign s_if.tvalid = s_valid[g];
    assign s_if.tlast  = s_last[g];
    assign s_if.tid    = '0;
    assign s_if.tdest  = '0;
    assign s_if.tuser  = s_user[g];
    assign s_ready[g]  = s_if.tready;
    assign m_if.tready = (g == 2 && rand_en) ? rnd_ready : m_hold[g];
    assign m_ready[g]  = m_if.tready;
    assign m_valid[g]  = m_if.tvalid;
    assign m_data[g]   = m_if.tdata;
    assign m_last[g]   = m_if.tlast;
    assign m_user[g]   = m_if.tuser[0];

    taxi_axis_cobs_encode_seg #(
      .MAX_SEG     (g == 0 ? 255 : 4),
      .APPEND_ZERO (g == 2 ? 1'b0 : 1'b1),
      .PREPEND_ZERO(g == 2 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .s_axis          (s_if),
      .m_axis          (m_if),
      .status_frame    (st_frame[g]),
      .status_bad_frame(st_bad[g]),
      .status_long_seg (st_long[g])
    );
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (m_valid[i] && m_ready[i]) begin
          out_q[i].push_back({m_user[i], m_last[i], m_data[i]});
          if (m_last[i]) n_last[i]++;
        end
        if (st_frame[i]) n_frame[i]++;
        if (st_bad[i]) n_bad[i]++;
        if (st_long[i]) n_long[i]++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input int d, input int b, input logic l, input logic u);
    int waited;
    waited     = 0;
    s_data[d]  = 8'(b);
    s_last[d]  = l;
    s_user[d]  = u;
    s_valid[d] = 1'b1;
    @(negedge clk);
    while (!s_ready[d] && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= LIMIT) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=%0d expected=<%0d", waited, LIMIT);
    end
    @(posedge clk);
    #1;
    s_valid[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input int fb[$], input logic user, input int max_gap);
    for (int i = 0; i < fb.size(); i++) begin
      tick($urandom_range(0, max_gap));
      send_byte(d, fb[i], i == fb.size() - 1, user && (i == fb.size() - 1));
    end
  endtask

  task automatic wait_frames(input int d, input int n, input string tag);
    int cyc;
    cyc = 0;
    while (n_last[d] < n && cyc < LIMIT) begin
      tick(1);
      cyc++;
    end
    tick(6);
    if (cyc >= LIMIT) begin
      total++;
      bad++;
      $error("FAIL %s.wait observed=%0d expected=%0d", tag, n_last[d], n);
    end
  endtask

  task automatic check_stream(input int d, input string tag, input logic [9:0] exp[$]);
    check({tag, ".len"}, out_q[d].size(), exp.size());
    for (int i = 0; i < exp.size() && i < out_q[d].size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(out_q[d][i]), 32'(exp[i]));
    out_q[d].delete();
    n_last[d] = 0;
  endtask

  // Reference COBS decode of instance 2's stream (leading 0x00, tlast on final byte).
  task automatic decode_check(input string tag);
    int pos;
    int bi;
    int code;
    logic done;
    logic [9:0] v;
    int dec[$];
    pos = 0;
    bi  = 0;
    for (int f = 0; f < sent_len.size(); f++) begin
      dec.delete();
      done = 1'b0;
      if (pos < out_q[2].size()) begin
        check($sformatf("%s.f%0d.pre", tag, f), 32'(out_q[2][pos]), 32'h0);
        pos++;
      end
      while (!done && pos < out_q[2].size()) begin
        v    = out_q[2][pos];
        pos++;
        code = int'(v[7:0]);
        done = v[8];
        for (int k = 1; k < code && !done && pos < out_q[2].size(); k++) begin
          v    = out_q[2][pos];
          pos++;
          dec.push_back(int'(v[7:0]));
          done = v[8];
        end
        if (!done && code != D2_MAX) dec.push_back(0);
      end
      check($sformatf("%s.f%0d.len", tag, f), dec.size(), sent_len[f]);
      for (int k = 0; k < sent_len[f]; k++)
        if (k < dec.size()) check($sformatf("%s.f%0d.b%0d", tag, f, k), dec[k], sent_b[bi + k]);
      bi += sent_len[f];
    end
    check({tag, ".tail"}, pos, out_q[2].size());
    out_q[2].delete();
    n_last[2] = 0;
    sent_b.delete();
    sent_len.delete();
  endtask

  task automatic random_frames(input int n, input string tag);
    int fb[$];
    int len;
    for (int f = 0; f < n; f++) begin
      fb.delete();
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++)
        fb.push_back(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 255)));
      sent_len.push_back(len);
      foreach (fb[i]) sent_b.push_back(fb[i]);
      send_frame(2, fb, 1'b0, 2);
    end
    wait_frames(2, n, tag);
    decode_check(tag);
  endtask

  initial begin
    logic [9:0] exp[$];
    int fb[$];
    for (int i = 0; i < 3; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      s_last[i]  = 1'b0;
      s_user[i]  = 1'b0;
      m_hold[i]  = 1'b1;
      n_last[i]  = 0;
      n_frame[i] = 0;
      n_bad[i]   = 0;
      n_long[i]  = 0;
    end

    // Reset state and the one-cycle tready hold-off after reset.
    tick(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.s_ready%0d", i), s_ready[i], 1'b0);
      check($sformatf("rst.m_valid%0d", i), m_valid[i], 1'b0);
      check($sformatf("rst.status%0d", i), {st_frame[i], st_bad[i], st_long[i]}, 3'b000);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.s_ready_low", s_ready[0], 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("post_rst.s_ready%0d", i), s_ready[i], 1'b1);

    // Basic frame with an embedded zero.
    fb = {'h11, 'h22, 'h00, 'h33};
    send_frame(0, fb, 1'b0, 0);
    wait_frames(0, 1, "t1");
    exp = {10'h003, 10'h011, 10'h022, 10'h002, 10'h033, 10'h100};
    check_stream(0, "t1", exp);
    check("t1.frame", n_frame[0], 1);
    check("t1.bad", n_bad[0], 0);

    // Frames made only of zeros, back to back.
    fb = {'h00};
    send_frame(0, fb, 1'b0, 0);
    fb = {'h00, 'h00};
    send_frame(0, fb, 1'b0, 0);
    wait_frames(0, 2, "t2");
    exp = {10'h001, 10'h001, 10'h100, 10'h001, 10'h001, 10'h001, 10'h100};
    check_stream(0, "t2", exp);
    check("t2.frame", n_frame[0], 3);

    // Exactly MAX_SEG-1 nonzero bytes ending the frame: no trailing 0x01.
    fb.delete();
    for (int i = 1; i <= 254; i++) fb.push_back(i);
    send_frame(0, fb, 1'b0, 0);
    wait_frames(0, 1, "t3");
    exp.delete();
    exp.push_back(10'h0FF);
    for (int i = 1; i <= 254; i++) exp.push_back(10'(i));
    exp.push_back(10'h100);
    check_stream(0, "t3", exp);
    check("t3.long", n_long[0], 1);

    // Errored frame: tuser on tlast drops that byte and flags the terminator.
    fb = {'hAA, 'hBB, 'hCC};
    send_frame(0, fb, 1'b1, 0);
    wait_frames(0, 1, "t5");
    exp = {10'h003, 10'h0AA, 10'h0BB, 10'h300};
    check_stream(0, "t5", exp);
    check("t5.bad", n_bad[0], 1);
    check("t5.frame", n_frame[0], 5);

    // Both banks and the skid register full: input must stall, output must hold.
    m_hold[0] = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(0, 0, 1'b0, 1'b0);
    tick(3);
    check("stall.s_ready", s_ready[0], 1'b0);
    check("stall.m_valid", m_valid[0], 1'b1);
    check("stall.m_data", m_data[0], 8'h01);
    m_hold[0] = 1'b1;
    send_byte(0, 0, 1'b1, 1'b0);
    wait_frames(0, 1, "stall");
    exp = {10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h001, 10'h100};
    check_stream(0, "stall", exp);
    check("stall.frame", n_frame[0], 6);

    // Short MAX_SEG with terminator.
    fb = {1, 2, 3, 4, 5};
    send_frame(1, fb, 1'b0, 0);
    wait_frames(1, 1, "t4a");
    exp = {10'h004, 10'h001, 10'h002, 10'h003, 10'h003, 10'h004, 10'h005, 10'h100};
    check_stream(1, "t4a", exp);
    check("t4a.long", n_long[1], 1);
    fb = {1, 2, 3};
    send_frame(1, fb, 1'b0, 0);
    wait_frames(1, 1, "t4b");
    exp = {10'h004, 10'h001, 10'h002, 10'h003, 10'h100};
    check_stream(1, "t4b", exp);
    check("t4b.long", n_long[1], 2);

    // Leading delimiter, no terminator: tlast on the final data byte.
    fb = {1, 2, 3, 4, 5};
    send_frame(2, fb, 1'b0, 0);
    wait_frames(2, 1, "t4c");
    exp = {10'h000, 10'h004, 10'h001, 10'h002, 10'h003, 10'h003, 10'h004, 10'h105};
    check_stream(2, "t4c", exp);
    check("t4c.frame", n_frame[2], 1);

    // Random frames with gaps on both sides.
    rand_en = 1'b1;
    random_frames(12, "rnd_a");
    rand_en = 1'b0;

    // Reset in the middle of a frame with output pending.
    m_hold[2] = 1'b0;
    send_byte(2, 5, 1'b0, 1'b0);
    send_byte(2, 6, 1'b0, 1'b0);
    send_byte(2, 0, 1'b0, 1'b0);
    send_byte(2, 7, 1'b0, 1'b0);
    tick(2);
    check("abort.pending", m_valid[2], 1'b1);
    rst = 1'b1;
    tick(2);
    check("abort.m_valid", m_valid[2], 1'b0);
    check("abort.s_ready", s_ready[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      out_q[i].delete();
      n_last[i] = 0;
    end
    rst       = 1'b0;
    m_hold[2] = 1'b1;
    tick(20);
    check("abort.no_output", out_q[2].size(), 0);

    rand_en = 1'b1;
    random_frames(6, "rnd_b");
    rand_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
